// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle processor control FSM (Moore decode, registered controls)
//
// Purpose: sequences FETCH/DECODE/execute/writeback states of a multicycle
// datapath and drives its register enables, strobes and mux selects.
// Ports:
//   clk, reset          clock; synchronous active-high reset to FETCH
//   op[OP_W-1:0]        opcode from the instruction register
//   zero                ALU zero flag, qualifies pc_en in BRANCH
//   mem_ready           memory handshake (only with MC_CTRL_MEM_WAIT_EN)
//   pc_en, ir_en, mdr_en, ab_en, aluout_en       register enables
//   mem_read, mem_write, reg_write               strobes
//   iord, reg_dst, mem_to_reg, alu_src_a         mux selects
//   alu_src_b, alu_op, pc_src                    2-bit selects
//   state[3:0]          current state (debug)
//   illegal             pulse in DECODE when the opcode is unknown
// Configuration: define MC_CTRL_MEM_WAIT_EN to make FETCH, MEM_RD and
// MEM_WR wait for mem_ready; otherwise every state lasts one cycle.

module mc_ctrl #(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic            ir_en,
    output logic            mdr_en,
    output logic            ab_en,
    output logic            aluout_en,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            iord,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_src,
    output logic [3:0]      state,
    output logic            illegal
);

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_en;
        logic       ir_en;
        logic       mdr_en;
        logic       ab_en;
        logic       aluout_en;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    state_t state_q;
    state_t nxt;
    ctrl_t  ctrl_q;
    logic   mem_done;
    logic   wait_state;
    logic   ready_gate;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    // Control word for a state; the register holds decode(state_q), so the
    // outputs stay a pure function of the current state.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.mem_read = 1'b1; c.ir_en = 1'b1; c.alu_src_b = 2'd1; c.pc_en = 1'b1; end
            DECODE:   begin c.ab_en = 1'b1; c.alu_src_b = 2'd3; c.aluout_en = 1'b1; end
            MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.aluout_en = 1'b1; end
            MEM_RD:   begin c.mem_read = 1'b1; c.iord = 1'b1; c.mdr_en = 1'b1; end
            MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEM_WR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
            EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = 2'd2; c.aluout_en = 1'b1; end
            R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            // pc_en in BRANCH is replaced by the zero flag at the output
            BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = 2'd1; c.pc_src = 2'd1; c.pc_en = 1'b1; end
            JUMP:     begin c.pc_src = 2'd2; c.pc_en = 1'b1; end
            ADDI_EX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.aluout_en = 1'b1; end
            ADDI_WB:  begin c.reg_write = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic op_known(input logic [OP_W-1:0] o);
        return (o == OP_R) || (o == OP_LW) || (o == OP_SW) ||
               (o == OP_BEQ) || (o == OP_J) || (o == OP_ADDI);
    endfunction

    always_comb begin
        nxt = FETCH;
        case (state_q)
            FETCH:    nxt = mem_done ? DECODE : FETCH;
            DECODE: begin
                if (op == OP_R)                         nxt = EXEC_R;
                else if ((op == OP_LW) || (op == OP_SW)) nxt = MEM_ADDR;
                else if (op == OP_BEQ)                  nxt = BRANCH;
                else if (op == OP_J)                    nxt = JUMP;
                else if (op == OP_ADDI)                 nxt = ADDI_EX;
                else                                    nxt = FETCH;
            end
            MEM_ADDR: nxt = (op == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   nxt = mem_done ? MEM_WB : MEM_RD;
            MEM_WR:   nxt = mem_done ? FETCH : MEM_WR;
            EXEC_R:   nxt = R_WB;
            ADDI_EX:  nxt = ADDI_WB;
            default:  nxt = FETCH;  // one-cycle states and unused codes 12-15
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= decode(FETCH);
        end else begin
            state_q <= nxt;
            ctrl_q  <= decode(nxt);
        end
    end

    // Enables that commit a memory result only fire on the completing cycle.
    assign wait_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign ready_gate = wait_state ? mem_done : 1'b1;

    assign pc_en      = (state_q == BRANCH) ? zero : (ctrl_q.pc_en & ready_gate);
    assign ir_en      = ctrl_q.ir_en & ready_gate;
    assign mdr_en     = ctrl_q.mdr_en & ready_gate;
    assign ab_en      = ctrl_q.ab_en;
    assign aluout_en  = ctrl_q.aluout_en;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign reg_write  = ctrl_q.reg_write;
    assign iord       = ctrl_q.iord;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign pc_src     = ctrl_q.pc_src;
    assign state      = state_q;
    assign illegal    = (state_q == DECODE) && !op_known(op);

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard testbench for mc_ctrl
//
// Per-cycle expectations are queued by the stimulus process and popped by a
// monitor on the falling clock edge.

module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_en, ir_en, mdr_en, ab_en, aluout_en;
    logic       mem_read, mem_write, reg_write;
    logic       iord, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;
    logic       illegal;

    mc_ctrl #(.OP_W(6)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_en(ir_en), .mdr_en(mdr_en), .ab_en(ab_en),
        .aluout_en(aluout_en), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .iord(iord), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en, ir_en, mdr_en, ab_en, aluout_en;
        logic       mem_read, mem_write, reg_write;
        logic       iord, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic [3:0] st;
        ctl_t       c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    // Output table for each state, written from the control-signal listing.
    function automatic ctl_t exp_ctl(input logic [3:0] s, input logic z, input logic r, input logic ill);
        ctl_t c;
        logic g;
        c = '0;
`ifdef MC_CTRL_MEM_WAIT_EN
        g = r;
`else
        g = 1'b1;
`endif
        case (s)
            4'd0:  begin c.mem_read = 1; c.ir_en = g; c.alu_src_b = 2'd1; c.pc_en = g; end
            4'd1:  begin c.ab_en = 1; c.alu_src_b = 2'd3; c.aluout_en = 1; end
            4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; c.aluout_en = 1; end
            4'd3:  begin c.mem_read = 1; c.iord = 1; c.mdr_en = g; end
            4'd4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            4'd5:  begin c.mem_write = 1; c.iord = 1; end
            4'd6:  begin c.alu_src_a = 1; c.alu_op = 2'd2; c.aluout_en = 1; end
            4'd7:  begin c.reg_write = 1; c.reg_dst = 1; end
            4'd8:  begin c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_src = 2'd1; c.pc_en = z; end
            4'd9:  begin c.pc_src = 2'd2; c.pc_en = 1; end
            4'd10: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; c.aluout_en = 1; end
            4'd11: begin c.reg_write = 1; end
            default: c = '0;
        endcase
        c.illegal = ill;
        return c;
    endfunction

    // Drive inputs for the current cycle and queue what the DUT must show in it.
    task automatic step(input logic [5:0] o, input logic z, input logic rdy, input logic rst,
                        input logic [3:0] est, input logic ill);
        exp_t e;
        @(posedge clk);
        #2;
        op = o; zero = z; mem_ready = rdy; reset = rst;
        e.st = est;
        e.c  = exp_ctl(est, z, rdy, ill);
        q.push_back(e);
    endtask

    // seq holds up to six 4-bit states, first state in the top nibble.
    task automatic instr(input logic [5:0] o, input logic z, input logic rdy, input int n,
                         input logic [23:0] seq);
        logic [3:0] s;
        for (int i = 0; i < n; i++) begin
            s = seq[23 - 4*i -: 4];
            step(o, z, rdy, 1'b0, s, (o == BAD) && (s == 4'd1));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        ctl_t a;
        cycle++;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {pc_en, ir_en, mdr_en, ab_en, aluout_en, mem_read, mem_write, reg_write,
                 iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal};
            checks++;
            if (state !== e.st) begin
                failures++;
                $display("FAIL state cycle %0d: got %0d required %0d", cycle, state, e.st);
            end
            checks++;
            if (a !== e.c) begin
                failures++;
                $display("FAIL ctrl cycle %0d state %0d: got %b required %b", cycle, e.st, a, e.c);
            end
            checks++;
            if (mem_write && reg_write) begin
                failures++;
                $display("FAIL write_excl cycle %0d: mem_write=%b reg_write=%b required not both",
                         cycle, mem_write, reg_write);
            end
        end
    end

    logic ign_rdy;

    initial begin
`ifdef MC_CTRL_MEM_WAIT_EN
        ign_rdy = 1'b1;
`else
        ign_rdy = 1'b0;   // mem_ready must have no effect in this build
`endif
        // Reset held across two rising edges; release checked on the FETCH that follows.
        step(6'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        instr(LW,   1'b0, 1'b1, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0});
        instr(SW,   1'b0, 1'b1, 4, {4'd0, 4'd1, 4'd2, 4'd5, 8'd0});
        instr(RT,   1'b0, 1'b1, 4, {4'd0, 4'd1, 4'd6, 4'd7, 8'd0});
        instr(ADDI, 1'b0, ign_rdy, 4, {4'd0, 4'd1, 4'd10, 4'd11, 8'd0});
        instr(BEQ,  1'b1, 1'b1, 3, {4'd0, 4'd1, 4'd8, 12'd0});
        instr(BEQ,  1'b0, 1'b1, 3, {4'd0, 4'd1, 4'd8, 12'd0});
        instr(JMP,  1'b0, 1'b1, 3, {4'd0, 4'd1, 4'd9, 12'd0});
        instr(BAD,  1'b0, 1'b1, 2, {4'd0, 4'd1, 16'd0});
        instr(RT,   1'b0, ign_rdy, 4, {4'd0, 4'd1, 4'd6, 4'd7, 8'd0});
        // Reset arriving while in MEM_RD aborts the load.
        step(LW, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        step(LW, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
        step(LW, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
        step(LW, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
        step(LW, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        step(LW, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
        step(LW, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
        step(LW, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
        step(LW, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0);
`ifdef MC_CTRL_MEM_WAIT_EN
        // Store with three wait cycles in MEM_WR, plus a stalled fetch.
        step(SW, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step(SW, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        step(SW, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
        step(SW, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
        step(SW, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
        step(SW, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
        step(SW, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
        step(SW, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0);
`endif
        step(6'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
